// File: rtl/timed_word_tx_pkg.sv
// Shared constants, serializer state type and sizing helpers for the
// timed word transmitter.
package timed_word_tx_pkg;

    localparam longint unsigned SECOND_NS = 64'd1_000_000_000;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;

    function automatic longint unsigned ns_per_clk(input longint unsigned freq);
        return SECOND_NS / freq;
    endfunction

    function automatic int unsigned num_bytes(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/timed_word_tx_period_pulse_gen.sv
// Programmable-period strobe: accumulates clock nanoseconds and fires once
// the accumulated time reaches the period, carrying the remainder forward.
module period_pulse_gen #(
    parameter int unsigned PERIOD_BITS = 64,
    parameter int unsigned NS_PER_CLK  = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period_ns,
    output logic                   pulse
);

    localparam logic [PERIOD_BITS:0] STEP = (PERIOD_BITS + 1)'(NS_PER_CLK);

    logic [PERIOD_BITS:0] acc_q;
    logic [PERIOD_BITS:0] acc_d;
    logic [PERIOD_BITS:0] sum;
    logic [PERIOD_BITS:0] period_ext;
    logic                 active;
    logic                 hit;

    always_comb begin
        period_ext = {1'b0, period_ns};
        sum        = acc_q + STEP;
        active     = enable && (period_ns != '0);
        hit        = active && (sum >= period_ext);
        acc_d      = '0;
        if (hit) begin
            acc_d = sum - period_ext;
        end else if (active) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Periods shorter than one clock would otherwise strobe while held in reset.
    assign pulse = hit && rst_n;

endmodule

// File: rtl/timed_word_tx.sv
// Snapshots a wide word on each frame strobe and streams it LSB byte first
// as back-to-back 8N1 UART bytes; also issues a trailing clear strobe.
module timed_word_tx
    import timed_word_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50_000_000,
    parameter int unsigned BAUD_RATE     = 230_400,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned PERIOD_BITS   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [PERIOD_BITS-1:0] frame_period_ns,
    input  logic                   frame_enable,
    input  logic                   tx_enable,
    output logic                   tx,
    output logic                   frame_pulse,
    output logic                   clear_pulse
);

    localparam int unsigned NS_PER_CLK = 32'(ns_per_clk(64'(CLK_FREQUENCY)));
    localparam int unsigned NBYTES     = num_bytes(WIDTH);
    localparam int unsigned SHIFT_W    = 8 * NBYTES;
    localparam int unsigned BIDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [PERIOD_BITS-1:0] BAUD_PERIOD_NS = PERIOD_BITS'(SECOND_NS / 64'(BAUD_RATE));
    localparam logic [BIDX_W-1:0]      LAST_BYTE      = BIDX_W'(NBYTES - 1);
    localparam logic [3:0]             STOP_BIT       = 4'd9;

    logic               baud_tick;
    logic               frame_tick;
    logic [WIDTH-1:0]   word_q;
    logic               clear_q;

    tx_state_e          state_q;
    tx_state_e          state_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;
    logic [BIDX_W-1:0]  byte_idx_q;
    logic [BIDX_W-1:0]  byte_idx_d;
    logic [3:0]         bit_idx_q;
    logic [3:0]         bit_idx_d;
    logic               tx_q;
    logic               tx_d;

    period_pulse_gen #(
        .PERIOD_BITS (PERIOD_BITS),
        .NS_PER_CLK  (NS_PER_CLK)
    ) u_baud_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (1'b1),
        .period_ns (BAUD_PERIOD_NS),
        .pulse     (baud_tick)
    );

    period_pulse_gen #(
        .PERIOD_BITS (PERIOD_BITS),
        .NS_PER_CLK  (NS_PER_CLK)
    ) u_frame_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (frame_enable),
        .period_ns (frame_period_ns),
        .pulse     (frame_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= frame_tick;
            if (frame_tick) begin
                word_q <= data_in;
            end
        end
    end

    // The load tick already emits the start bit, so words follow each other
    // with no idle bit; bit_idx 0 is the start bit of the following bytes.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (tx_enable) begin
                        shift_d    = SHIFT_W'(word_q);
                        byte_idx_d = '0;
                        bit_idx_d  = 4'd1;
                        tx_d       = 1'b0;
                        state_d    = SEND;
                    end
                end
                SEND: begin
                    if (bit_idx_q == 4'd0) begin
                        tx_d      = 1'b0;
                        bit_idx_d = 4'd1;
                    end else if (bit_idx_q < STOP_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        tx_d      = 1'b1;
                        bit_idx_d = 4'd0;
                        if ((byte_idx_q == LAST_BYTE) || !tx_enable) begin
                            state_d = IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + BIDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign tx          = tx_q;
    assign frame_pulse = frame_tick;
    assign clear_pulse = clear_q;

endmodule

// File: tb/tb_timed_word_tx.sv
// Directed self-checking bench for timed_word_tx: frame strobes, fractional
// periods, serial word framing, overlap, early disable and async reset.
module tb_timed_word_tx;

    localparam int unsigned BIT_CYC = 217;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [63:0] frame_period_ns;
    logic        frame_enable;
    logic        tx_enable;
    logic        tx;
    logic        frame_pulse;
    logic        clear_pulse;

    int checkCount = 0;
    int failCount  = 0;
    int pulseCount;

    // Line bits in time order (bit 0 first): 16'hA55A as two 8N1 bytes, then
    // byte 0 of 16'h1234 followed by three idle-high bit slots.
    logic [19:0] word0Bits = 20'b1101001010_1010110100;
    logic [12:0] word1Bits = 13'b111_1001101000;

    timed_word_tx #(
        .CLK_FREQUENCY (50_000_000),
        .BAUD_RATE     (230_400),
        .WIDTH         (16),
        .PERIOD_BITS   (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_in         (data_in),
        .frame_period_ns (frame_period_ns),
        .frame_enable    (frame_enable),
        .tx_enable       (tx_enable),
        .tx              (tx),
        .frame_pulse     (frame_pulse),
        .clear_pulse     (clear_pulse)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        if (n == 500)   data_in   = 16'h1234;
        if (n == 5208)  tx_enable = 1'b0;
        if (n == 11000) tx_enable = 1'b1;
        if (n == 11104) rst_n     = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        frame_enable    = 1'b1;
        frame_period_ns = 64'd10;
        tx_enable       = 1'b0;
        data_in         = 16'hA55A;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_frame", 32'(frame_pulse), 32'd0);
        checkOutput("reset_clear", 32'(clear_pulse), 32'd0);

        @(negedge clk);
        rst_n           = 1'b1;
        frame_period_ns = 64'd100;
        tx_enable       = 1'b1;

        for (int n = 1; n <= 11104; n++) begin
            @(negedge clk);
            applyStimulus(n);
            #1;
            if (n <= 20) begin
                checkOutput($sformatf("frame100_n%0d", n), 32'(frame_pulse), 32'(n % 5 == 4));
                checkOutput($sformatf("clear100_n%0d", n), 32'(clear_pulse), 32'(n % 5 == 0));
            end
            if (n == 216) checkOutput("tx_idle_before_tick", 32'(tx), 32'd1);
            if (n >= 217 && n < 217 + 20 * BIT_CYC) begin
                if ((n - 217) % BIT_CYC == 0 || (n - 217) % BIT_CYC == BIT_CYC - 1)
                    checkOutput($sformatf("tx_w0_b%0d_n%0d", (n - 217) / BIT_CYC, n), 32'(tx),
                                32'(word0Bits[(n - 217) / BIT_CYC]));
            end
            if (n >= 4557 && n < 4557 + 13 * BIT_CYC) begin
                if ((n - 4557) % BIT_CYC == 0 || (n - 4557) % BIT_CYC == BIT_CYC - 1)
                    checkOutput($sformatf("tx_w1_b%0d_n%0d", (n - 4557) / BIT_CYC, n), 32'(tx),
                                32'(word1Bits[(n - 4557) / BIT_CYC]));
            end
            if (n == 11103) checkOutput("tx_start_before_reset", 32'(tx), 32'd0);
            if (n == 11104) begin
                checkOutput("async_reset_tx", 32'(tx), 32'd1);
                checkOutput("async_reset_frame", 32'(frame_pulse), 32'd0);
                checkOutput("async_reset_clear", 32'(clear_pulse), 32'd0);
            end
        end

        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        tx_enable = 1'b0;
        #1;
        checkOutput("post_reset_frame_n0", 32'(frame_pulse), 32'd0);

        pulseCount = 0;
        for (int n = 1; n <= 380; n++) begin
            @(negedge clk);
            if (n == 5)   frame_period_ns = 64'd30;
            if (n == 306) frame_period_ns = 64'd0;
            if (n == 356) begin
                frame_period_ns = 64'd100;
                frame_enable    = 1'b0;
            end
            if (n == 376) frame_enable = 1'b1;
            #1;
            if (n <= 5) begin
                checkOutput($sformatf("post_reset_frame_n%0d", n), 32'(frame_pulse), 32'(n == 4));
                checkOutput($sformatf("post_reset_clear_n%0d", n), 32'(clear_pulse), 32'(n == 5));
            end
            if (n >= 6 && n <= 17) begin
                checkOutput($sformatf("frac_frame_n%0d", n), 32'(frame_pulse), 32'(n % 3 != 2));
                checkOutput($sformatf("frac_clear_n%0d", n), 32'(clear_pulse), 32'((n - 1) % 3 != 2));
            end
            if (n >= 6 && n <= 305 && frame_pulse) pulseCount++;
            if (n == 305) begin
                checkOutput("frac_count_300", 32'(pulseCount), 32'd200);
                pulseCount = 0;
            end
            if (n >= 306 && n <= 355 && frame_pulse) pulseCount++;
            if (n == 355) begin
                checkOutput("zero_period_count", 32'(pulseCount), 32'd0);
                pulseCount = 0;
            end
            if (n >= 356 && n <= 375 && frame_pulse) pulseCount++;
            if (n == 375) checkOutput("disabled_count", 32'(pulseCount), 32'd0);
            if (n >= 376) begin
                checkOutput($sformatf("reenable_frame_n%0d", n), 32'(frame_pulse), 32'(n == 380));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
